// File: rtl/dds_rx_pkg.sv
// dds_rx_pkg: shared framing constants and receiver FSM state type
package dds_rx_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] COMMIT_ID = 8'hFF;
  typedef enum logic [1:0] {IDLE, CHAN, DATA, CSUM} rx_state_t;
endpackage

// File: rtl/rx_timeout_cnt.sv
// rx_timeout_cnt: inter-byte idle counter, expires after TIMEOUT_CYC silent running cycles
module rx_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  // a byte in the same cycle suppresses expiry
  assign expire = run && !clear && r_cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (clear || !run || expire) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/phase_cmd_rx.sv
// phase_cmd_rx: UART framed phase-word receiver with shadow registers, commit and error reporting
module phase_cmd_rx
  import dds_rx_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PHASE_W     = 10,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      RX_Done_Sig,
  input  logic [7:0]                RX_Data,
  output logic                      RX_En_Sig,
  output logic [NUM_CH*PHASE_W-1:0] phase_o,
  output logic                      update_pulse,
  output logic                      err_csum,
  output logic                      err_chan,
  output logic                      err_timeout,
  output logic [7:0]                err_cnt
);
  localparam int NB = (PHASE_W + 7) / 8;
  localparam int AW = 8 * NB;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  rx_state_t r_state, w_next;
  logic [AW-1:0] r_asm;
  logic [BW-1:0] r_bcnt;
  logic [7:0] r_ch, r_csum, r_err_cnt;
  logic [PHASE_W-1:0] r_shadow [NUM_CH];
  logic [NUM_CH*PHASE_W-1:0] r_phase;
  logic r_en, r_upd, r_ecs, r_ech, r_eto;
  logic w_expire, w_last, w_chan_ok, w_in_csum, w_match;
  logic w_write, w_commit, w_csum_err, w_bad_chan, w_err;
  assign w_chan_ok  = RX_Data < 8'(NUM_CH);
  assign w_last     = r_bcnt == BW'(NB - 1);
  assign w_in_csum  = RX_Done_Sig && r_state == CSUM;
  assign w_match    = RX_Data == r_csum;
  assign w_write    = w_in_csum && w_match && r_ch != COMMIT_ID;
  assign w_commit   = w_in_csum && w_match && r_ch == COMMIT_ID;
  assign w_csum_err = w_in_csum && !w_match;
  assign w_bad_chan = RX_Done_Sig && r_state == CHAN && !w_chan_ok && RX_Data != COMMIT_ID;
  assign w_err      = w_csum_err || w_bad_chan || w_expire;
  rx_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (CLK),
    .rst_n (RSTn),
    .clear (RX_Done_Sig),
    .run   (r_state != IDLE),
    .expire(w_expire)
  );
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (RX_Done_Sig)
      case (r_state)
        IDLE:    w_next = (RX_Data == SYNC_BYTE) ? CHAN : IDLE;
        CHAN:    w_next = w_chan_ok ? DATA : (RX_Data == COMMIT_ID) ? CSUM : IDLE;
        DATA:    w_next = w_last ? CSUM : DATA;
        default: w_next = IDLE;
      endcase
    else if (w_expire) w_next = IDLE;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      r_en      <= 1'b0;
      r_upd     <= 1'b0;
      r_ecs     <= 1'b0;
      r_ech     <= 1'b0;
      r_eto     <= 1'b0;
      r_err_cnt <= '0;
      r_asm     <= '0;
      r_bcnt    <= '0;
      r_ch      <= '0;
      r_csum    <= '0;
      r_phase   <= '0;
      for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
    end else begin
      r_en  <= 1'b1;
      r_upd <= w_commit;
      r_ecs <= w_csum_err;
      r_ech <= w_bad_chan;
      r_eto <= w_expire;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (RX_Done_Sig && r_state == CHAN) begin
        r_ch   <= RX_Data;
        r_csum <= RX_Data;
        r_bcnt <= '0;
      end
      if (RX_Done_Sig && r_state == DATA) begin
        r_asm  <= AW'({r_asm, RX_Data});
        r_csum <= r_csum ^ RX_Data;
        r_bcnt <= r_bcnt + 1'b1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_write && r_ch == 8'(k)) r_shadow[k] <= r_asm[PHASE_W-1:0];
        if (w_commit) r_phase[k*PHASE_W +: PHASE_W] <= r_shadow[k];
      end
    end
  assign RX_En_Sig    = r_en;
  assign phase_o      = r_phase;
  assign update_pulse = r_upd;
  assign err_csum     = r_ecs;
  assign err_chan     = r_ech;
  assign err_timeout  = r_eto;
  assign err_cnt      = r_err_cnt;
endmodule

// File: tb/tb_phase_cmd_rx.sv
// tb_phase_cmd_rx: directed table, corner sequences and random traffic against a frame-level model
module tb_phase_cmd_rx;
  localparam int NCH = 4, PW = 10, NB = 2, TO = 100;
  logic clk = 1'b0, RSTn, done, RX_En_Sig, update_pulse, err_csum, err_chan, err_timeout;
  logic [7:0] data, err_cnt;
  logic [NCH*PW-1:0] phase_o;
  int vectors = 0, miss = 0;
  phase_cmd_rx #(.NUM_CH(NCH), .PHASE_W(PW), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RSTn(RSTn), .RX_Done_Sig(done), .RX_Data(data), .RX_En_Sig(RX_En_Sig),
    .phase_o(phase_o), .update_pulse(update_pulse), .err_csum(err_csum), .err_chan(err_chan),
    .err_timeout(err_timeout), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  // frame-level reference: bytes of the current frame, idle time, shadow and live phases
  logic [7:0] fr[$];
  int idle, m_cnt;
  logic [PW-1:0] sh[NCH], ph[NCH];
  bit m_upd, m_ecs, m_ech, m_eto, m_en;
  function automatic void m_reset();
    fr.delete(); idle = 0; m_cnt = 0; m_en = 0;
    m_upd = 0; m_ecs = 0; m_ech = 0; m_eto = 0;
    foreach (sh[i]) begin sh[i] = '0; ph[i] = '0; end
  endfunction
  function automatic void m_err();
    if (m_cnt < 255) m_cnt++;
  endfunction
  function automatic void m_step(input bit d, input logic [7:0] b);
    logic [7:0] x;
    int v;
    m_upd = 0; m_ecs = 0; m_ech = 0; m_eto = 0; m_en = 1;
    if (d) begin
      idle = 0;
      if (fr.size() == 0) begin
        if (b == 8'hA5) fr.push_back(b);
      end else begin
        fr.push_back(b);
        if (fr.size() == 2 && fr[1] != 8'hFF && fr[1] >= NCH) begin
          m_ech = 1; m_err(); fr.delete();
        end else if (fr.size() == ((fr[1] == 8'hFF) ? 3 : 3 + NB)) begin
          x = 0; v = 0;
          for (int i = 1; i < fr.size() - 1; i++) x ^= fr[i];
          if (x != b) begin
            m_ecs = 1; m_err();
          end else if (fr[1] == 8'hFF) begin
            m_upd = 1;
            foreach (sh[i]) ph[i] = sh[i];
          end else begin
            for (int i = 2; i < fr.size() - 1; i++) v = (v << 8) | int'(fr[i]);
            sh[fr[1][1:0]] = v[PW-1:0];
          end
          fr.delete();
        end
      end
    end else if (fr.size() > 0) begin
      idle++;
      if (idle == TO) begin m_eto = 1; m_err(); fr.delete(); idle = 0; end
    end
  endfunction
  task automatic cycle(input bit d, input logic [7:0] b);
    logic [52:0] act, exp;
    done = d; data = b;
    m_step(d, b);
    @(posedge clk); #1;
    done = 0;
    act = {phase_o, update_pulse, err_csum, err_chan, err_timeout, err_cnt, RX_En_Sig};
    exp = {ph[3], ph[2], ph[1], ph[0], m_upd, m_ecs, m_ech, m_eto, 8'(m_cnt), m_en};
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL cycle t=%0t got {phase,upd,ecs,ech,eto,cnt,en}=%h expected %h", $time, act, exp);
    end
  endtask
  task automatic tx(input logic [7:0] b);
    cycle(1, b);
  endtask
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] rb();
    int r;
    r = $urandom_range(0, 9);
    return (r < 3) ? 8'hA5 : (r < 5) ? 8'hFF : (r < 7) ? 8'($urandom_range(0, 4)) : 8'($urandom);
  endfunction
  typedef struct {
    int          n;
    logic [47:0] b;
    logic [3:0]  fl;
    logic [39:0] ph;
    logic [7:0]  cnt;
  } vec_t;
  vec_t tbl[7];
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{5, 48'hA5_02_01_55_56_00, 4'b0000, 40'h00_0000_0000, 8'd0};
    tbl[1] = '{3, 48'hA5_FF_FF_00_00_00, 4'b1000, 40'h00_1550_0000, 8'd0};
    tbl[2] = '{5, 48'hA5_01_00_10_00_00, 4'b0100, 40'h00_1550_0000, 8'd1};
    tbl[3] = '{2, 48'hA5_07_00_00_00_00, 4'b0010, 40'h00_1550_0000, 8'd2};
    tbl[4] = '{5, 48'hA5_00_00_0A_0A_00, 4'b0000, 40'h00_1550_0000, 8'd2};
    tbl[5] = '{5, 48'hA5_00_FF_FF_00_00, 4'b0000, 40'h00_1550_0000, 8'd2};
    tbl[6] = '{3, 48'hA5_FF_FF_00_00_00, 4'b1000, 40'h00_1550_03FF, 8'd2};
    done = 0; data = 0; RSTn = 0;
    m_reset();
    #1;
    chk("reset_outputs", {update_pulse, err_csum, err_chan, err_timeout, err_cnt, RX_En_Sig, phase_o[26:0]}, 40'h0);
    chk("reset_phase", phase_o, 40'h0);
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1;
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < tbl[r].n; i++) tx(tbl[r].b[47-8*i -: 8]);
      chk($sformatf("tbl%0d_flags", r), {36'd0, update_pulse, err_csum, err_chan, err_timeout}, {36'd0, tbl[r].fl});
      chk($sformatf("tbl%0d_phase", r), phase_o, tbl[r].ph);
      chk($sformatf("tbl%0d_errcnt", r), {32'd0, err_cnt}, {32'd0, tbl[r].cnt});
      cycle(0, 0);
      chk($sformatf("tbl%0d_strobe_1cyc", r), {36'd0, update_pulse, err_csum, err_chan, err_timeout}, 40'd0);
    end
    tx(8'hA5); tx(8'h03);
    repeat (TO - 1) cycle(0, 0);
    chk("timeout_early", {39'd0, err_timeout}, 40'd0);
    cycle(0, 0);
    chk("timeout_fire", {39'd0, err_timeout}, 40'd1);
    chk("timeout_errcnt", {32'd0, err_cnt}, 40'd3);
    tx(8'h03); tx(8'h12);
    tx(8'hA5); tx(8'h01); tx(8'h00); tx(8'h12); tx(8'h13);
    tx(8'hA5); tx(8'hFF); tx(8'hFF);
    chk("after_timeout_commit", phase_o, 40'h00_1550_4BFF);
    tx(8'hA5); tx(8'h03);
    repeat (TO - 1) cycle(0, 0);
    tx(8'h00);
    chk("byte_beats_timeout", {39'd0, err_timeout}, 40'd0);
    repeat (TO - 1) cycle(0, 0);
    tx(8'h05); tx(8'h06);
    chk("late_frame_csum_ok", {39'd0, err_csum}, 40'd0);
    tx(8'hA5); tx(8'hFF); tx(8'hFF);
    chk("ch3_commit", phase_o, 40'h01_5550_4BFF);
    chk("ch3_errcnt", {32'd0, err_cnt}, 40'd3);
    tx(8'hA5); tx(8'h02); tx(8'h01);
    RSTn = 0;
    #1;
    m_reset();
    chk("midframe_reset_outputs", {update_pulse, err_csum, err_chan, err_timeout, err_cnt, RX_En_Sig, phase_o[26:0]}, 40'h0);
    chk("midframe_reset_phase", phase_o, 40'h0);
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1;
    tx(8'h55); tx(8'h56);
    tx(8'hA5); tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h05);
    tx(8'hA5); tx(8'hFF); tx(8'hFF);
    chk("fresh_frame_commit", phase_o, 40'h00_3040_0000);
    chk("fresh_errcnt", {32'd0, err_cnt}, 40'd0);
    chk("fresh_en", {39'd0, RX_En_Sig}, 40'd1);
    repeat (260) begin tx(8'hA5); tx(8'h07); end
    chk("errcnt_saturate", {32'd0, err_cnt}, 40'd255);
    for (int it = 0; it < 400; it++) begin
      int k;
      logic [7:0] ch, d1, d2;
      k = $urandom_range(0, 9);
      ch = 8'($urandom_range(0, 3));
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      if (k < 3) begin tx(8'hA5); tx(ch); tx(d1); tx(d2); tx(ch ^ d1 ^ d2); end
      else if (k == 3) begin tx(8'hA5); tx(8'hFF); tx(8'hFF); end
      else if (k == 4) begin
        tx(8'hA5); tx(8'($urandom_range(0, 5))); tx(d1); tx(d2); tx(8'($urandom_range(0, 3)) ^ d1 ^ d2);
      end
      else if (k == 5) begin tx(8'hA5); repeat ($urandom_range(TO - 5, TO + 5)) cycle(0, 0); end
      else begin tx(rb()); repeat ($urandom_range(0, 2)) cycle(0, 0); end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/phase_cmd_rx.md
PHASE_CMD_RX -- requirements
Module: phase_cmd_rx

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of phase channels (1..254).
REQ-002 The block SHALL have parameter PHASE_W, default 10, giving the phase word width (1..32).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000, giving the maximum number of idle clock cycles allowed between bytes of one frame.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 The block SHALL have port RSTn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port RX_Done_Sig, input, 1 bit: one-cycle strobe meaning RX_Data holds a valid byte.
REQ-007 The block SHALL have port RX_Data, input, 8 bits: received UART byte.
REQ-008 The block SHALL have port RX_En_Sig, output, 1 bit: enable to the UART receiver.
REQ-009 The block SHALL have port phase_o, output, NUM_CH*PHASE_W bits: committed phases, with channel k at bits [k*PHASE_W +: PHASE_W].
REQ-010 The block SHALL have port update_pulse, output, 1 bit: one-cycle strobe when phase_o changes by commit.
REQ-011 The block SHALL have ports err_csum, err_chan and err_timeout, each output, 1 bit: one-cycle error strobes.
REQ-012 The block SHALL have port err_cnt, output, 8 bits: saturating count of all errors.

Function
REQ-013 The byte count per word SHALL be NB = ceil(PHASE_W/8), computed as a derived constant.
REQ-014 A write frame SHALL be: SYNC 0xA5, channel byte, NB data bytes MSB-first, then checksum = XOR of the channel and data bytes.
REQ-015 A commit frame SHALL be: SYNC 0xA5, channel byte 0xFF, then checksum 0xFF.
REQ-016 The FSM SHALL have states IDLE, CHAN, DATA and CSUM, and SHALL act only in cycles where RX_Done_Sig=1.
REQ-017 In IDLE, 0xA5 SHALL move the FSM to CHAN; all other bytes SHALL be ignored.
REQ-018 In CHAN, a channel byte <NUM_CH SHALL go to DATA and 0xFF SHALL go to CSUM; any other value SHALL pulse err_chan and return to IDLE.
REQ-019 DATA SHALL shift bytes into an 8*NB-bit assembly register and go to CSUM after the NB-th byte; 0xA5 received inside DATA SHALL be treated as data.
REQ-020 In CSUM, on a checksum match, a write frame SHALL load the low PHASE_W bits of the assembly register into shadow[ch], with upper bits discarded.
REQ-021 In CSUM, on a checksum match, a commit frame SHALL copy all shadows to phase_o and pulse update_pulse.
REQ-022 In CSUM, on a checksum mismatch, the block SHALL pulse err_csum and leave shadow and phase_o unchanged.
REQ-023 CSUM SHALL always return to IDLE.
REQ-024 Latency SHALL be: shadow, phase_o, update_pulse and error strobes valid in the cycle after the triggering RX_Done_Sig cycle; no byte SHALL be lost back-to-back.
REQ-025 The timeout counter SHALL reload to 0 on every RX_Done_Sig, count while not in IDLE, and at TIMEOUT_CYC pulse err_timeout and force IDLE.
REQ-026 If RX_Done_Sig coincides with the timeout, the byte SHALL win and no timeout SHALL occur.
REQ-027 err_cnt SHALL increment by 1 per error strobe and saturate at 255; at most one error strobe SHALL occur per cycle.
REQ-028 RX_En_Sig SHALL be 1 from the first clock edge after RSTn release and remain 1.

Reset
REQ-029 RSTn=0 SHALL asynchronously force state IDLE, phase_o=0, all shadows=0, assembly register=0, update_pulse=0, all err_* outputs=0, err_cnt=0, timeout counter=0 and RX_En_Sig=0.
REQ-030 A frame in progress when reset is asserted SHALL be discarded entirely.

Structure
REQ-031 Package dds_rx_pkg SHALL hold SYNC_BYTE=8'hA5, COMMIT_ID=8'hFF and the FSM state enum.
REQ-032 The timeout counter SHALL be the single sub-module rx_timeout_cnt, parametrised by TIMEOUT_CYC, with inputs clear and run and output expire.

Verification (NUM_CH=4, PHASE_W=10, NB=2, TIMEOUT_CYC=100)
REQ-033 Bench SHALL cover: write A5 02 01 55 56 -> shadow2=0x155, phase_o unchanged; then A5 FF FF -> phase_o[29:20]=0x155 and update_pulse high for exactly 1 cycle.
REQ-034 Bench SHALL cover: A5 01 00 10 00 (bad checksum) -> err_csum pulse, err_cnt=1, shadow1 unchanged.
REQ-035 Bench SHALL cover: A5 07 -> err_chan pulse, FSM in IDLE; the following valid frame A5 00 00 0A 0A is accepted (shadow0=0x00A).
REQ-036 Bench SHALL cover: A5 03 then 100 silent cycles -> err_timeout pulse; subsequent bytes 03 12 ignored until the next A5.
REQ-037 Bench SHALL cover: A5 00 FF FF 00 -> shadow0=0x3FF (upper bits truncated); after commit, phase_o[9:0]=0x3FF.
REQ-038 Bench SHALL cover: RSTn low after A5 02 01 -> all outputs 0 and RX_En_Sig 0; after release, 55 56 is ignored and a fresh full frame is accepted.
